multicycle_alu: RTL and testbench

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

---
 rtl/multicycle_alu_pkg.sv | 23 ++
 rtl/multicycle_alu_if.sv | 27 ++
 rtl/multicycle_alu_divider.sv | 53 +++++
 rtl/multicycle_alu.sv | 157 +++++++++++++++
 tb/tb_multicycle_alu.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_alu_pkg.sv
// multicycle_alu_pkg: opcodes, FSM state and flag bundle shared by the multicycle ALU
package multicycle_alu_pkg;
  localparam logic [3:0] OP_SLL  = 4'd0;
  localparam logic [3:0] OP_SRA  = 4'd1;
  localparam logic [3:0] OP_SRL  = 4'd2;
  localparam logic [3:0] OP_MUL  = 4'd3;
  localparam logic [3:0] OP_DIV  = 4'd4;
  localparam logic [3:0] OP_ADD  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_AND  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_XOR  = 4'd9;
  localparam logic [3:0] OP_NOR  = 4'd10;
  localparam logic [3:0] OP_SLT  = 4'd11;
  localparam logic [3:0] OP_SLTU = 4'd12;
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  typedef struct packed {
    logic equal;
    logic overflow;
    logic uof;
    logic div_zero;
  } flags_t;
endpackage

// File: rtl/multicycle_alu_if.sv
// multicycle_alu_if: request/response bus of the multicycle ALU
// request: S, X, Y, in_valid -> in_ready; response: out_valid, Result, Result2, flags <- out_ready
interface multicycle_alu_if #(
  parameter int WIDTH = 32
);
  logic [3:0] S;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] Result;
  logic [WIDTH-1:0] Result2;
  logic Equal;
  logic Overflow;
  logic UOF;
  logic DivZero;
  modport master (
    output S, X, Y, in_valid, out_ready,
    input in_ready, out_valid, Result, Result2, Equal, Overflow, UOF, DivZero
  );
  modport slave (
    input S, X, Y, in_valid, out_ready,
    output in_ready, out_valid, Result, Result2, Equal, Overflow, UOF, DivZero
  );
endinterface

// File: rtl/multicycle_alu_divider.sv
// multicycle_alu_divider: unsigned restoring divider, one quotient bit per cycle
// ports: clk, rst_n, start, dividend, divisor -> busy, done (1-cycle pulse), quotient, remainder
module multicycle_alu_divider
  import multicycle_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH-1:0] dvs, r_in, q_in, d_in;
  logic [WIDTH:0] shifted, diff;
  logic [CW-1:0] cnt;
  logic ge;
  // the first step runs on the start edge itself so the last one lands WIDTH-1 edges later
  assign r_in = start ? '0 : remainder;
  assign q_in = start ? dividend : quotient;
  assign d_in = start ? divisor : dvs;
  assign shifted = {r_in, q_in[WIDTH-1]};
  assign diff = shifted - {1'b0, d_in};
  assign ge = !diff[WIDTH];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
      cnt <= '0;
      dvs <= '0;
      quotient <= '0;
      remainder <= '0;
    end else begin
      done <= busy && cnt == CW'(WIDTH-1);
      if (start) begin
        dvs <= divisor;
        cnt <= CW'(1);
        busy <= 1'b1;
      end else if (busy) begin
        cnt <= cnt + 1'b1;
        busy <= cnt != CW'(WIDTH-1);
      end
      if (start || busy) begin
        remainder <= ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quotient <= {q_in[WIDTH-2:0], ge};
      end
    end
endmodule

// File: rtl/multicycle_alu.sv
// multicycle_alu: single-cycle ALU ops plus iterative signed MUL and optional signed DIV
// ports: clk, rst_n (async, active-low), bus (multicycle_alu_if.slave)
// macro MULTICYCLE_ALU_DIV_EN builds the divider; without it opcode 4 is reserved
module multicycle_alu
  import multicycle_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic clk,
  input logic rst_n,
  multicycle_alu_if.slave bus
);
  localparam int SW = $clog2(WIDTH);
  state_t state;
  flags_t flags;
  logic in_ready, out_valid, neg_p, accept, eq, single, ovf, uof;
  logic [WIDTH-1:0] res, res2, mcand, r, x_mag, y_mag;
  logic [2*WIDTH-1:0] acc, mul_next, prod;
  logic [WIDTH:0] add_w, sub_w, mul_sum;
  logic [SW-1:0] cnt, sh;
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction
  assign accept = bus.in_valid && in_ready;
  assign eq = bus.X == bus.Y;
  assign sh = bus.Y[SW-1:0];
  assign x_mag = mag(bus.X);
  assign y_mag = mag(bus.Y);
  assign add_w = {1'b0, bus.X} + {1'b0, bus.Y};
  assign sub_w = {1'b0, bus.X} - {1'b0, bus.Y};
  assign single = bus.S < OP_MUL || (bus.S >= OP_ADD && bus.S <= OP_SLTU);
  assign ovf = bus.S == OP_ADD ? bus.X[WIDTH-1] == bus.Y[WIDTH-1] && add_w[WIDTH-1] != bus.X[WIDTH-1]
             : bus.S == OP_SUB ? bus.X[WIDTH-1] != bus.Y[WIDTH-1] && sub_w[WIDTH-1] != bus.X[WIDTH-1]
             : 1'b0;
  assign uof = bus.S == OP_ADD ? add_w[WIDTH] : bus.S == OP_SUB ? sub_w[WIDTH] : 1'b0;
  // acc = {partial sum, remaining multiplier bits}; one multiplier bit retired per cycle
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{acc[0]}} & mcand};
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};
  assign prod = neg_p ? -mul_next : mul_next;
  always_comb
    case (bus.S)
      OP_SLL:  r = bus.X << sh;
      OP_SRA:  r = $unsigned($signed(bus.X) >>> sh);
      OP_SRL:  r = bus.X >> sh;
      OP_ADD:  r = add_w[WIDTH-1:0];
      OP_SUB:  r = sub_w[WIDTH-1:0];
      OP_AND:  r = bus.X & bus.Y;
      OP_OR:   r = bus.X | bus.Y;
      OP_XOR:  r = bus.X ^ bus.Y;
      OP_NOR:  r = ~(bus.X | bus.Y);
      OP_SLT:  r = {{(WIDTH-1){1'b0}}, $signed(bus.X) < $signed(bus.Y)};
      OP_SLTU: r = {{(WIDTH-1){1'b0}}, bus.X < bus.Y};
      OP_MUL, OP_DIV: r = '0;
      default: r = '0;
    endcase
`ifdef MULTICYCLE_ALU_DIV_EN
  logic div_start, div_busy, div_done, neg_r;
  logic [WIDTH-1:0] quo, rem;
  assign div_start = accept && bus.S == OP_DIV && bus.Y != '0;
  multicycle_alu_divider #(.WIDTH(WIDTH)) u_div (
    .clk(clk),
    .rst_n(rst_n),
    .start(div_start),
    .dividend(x_mag),
    .divisor(y_mag),
    .busy(div_busy),
    .done(div_done),
    .quotient(quo),
    .remainder(rem)
  );
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      in_ready <= 1'b0;
      out_valid <= 1'b0;
      res <= '0;
      res2 <= '0;
      flags <= '0;
      acc <= '0;
      mcand <= '0;
      cnt <= '0;
      neg_p <= 1'b0;
`ifdef MULTICYCLE_ALU_DIV_EN
      neg_r <= 1'b0;
`endif
    end else
      case (state)
        IDLE: begin
          in_ready <= !accept;
          if (accept) begin
            neg_p <= bus.X[WIDTH-1] ^ bus.Y[WIDTH-1];
            cnt <= '0;
            acc <= {{WIDTH{1'b0}}, y_mag};
            mcand <= x_mag;
            res <= '0;
            res2 <= '0;
            flags <= '{eq, 1'b0, 1'b0, 1'b0};
            if (bus.S == OP_MUL) state <= MUL;
`ifdef MULTICYCLE_ALU_DIV_EN
            else if (bus.S == OP_DIV && bus.Y == '0) begin
              state <= DONE;
              out_valid <= 1'b1;
              res <= '1;
              res2 <= bus.X;
              flags <= '{eq, 1'b0, 1'b0, 1'b1};
            end else if (bus.S == OP_DIV) begin
              state <= DIV;
              neg_r <= bus.X[WIDTH-1];
              // MIN / -1: magnitude quotient 2^(WIDTH-1) negates back to MIN, only the flag is extra
              flags.overflow <= bus.X == {1'b1, {(WIDTH-1){1'b0}}} && bus.Y == '1;
            end
`endif
            else begin
              state <= DONE;
              out_valid <= 1'b1;
              res <= r;
              flags <= '{eq && single, ovf, uof, 1'b0};
            end
          end
        end
        MUL: begin
          acc <= mul_next;
          cnt <= cnt + 1'b1;
          if (cnt == SW'(WIDTH-1)) begin
            state <= DONE;
            out_valid <= 1'b1;
            {res2, res} <= prod;
          end
        end
`ifdef MULTICYCLE_ALU_DIV_EN
        DIV: if (div_done && !div_busy) begin
          state <= DONE;
          out_valid <= 1'b1;
          res <= neg_p ? -quo : quo;
          res2 <= neg_r ? -rem : rem;
        end
`endif
        DONE: if (bus.out_ready) begin
          state <= IDLE;
          out_valid <= 1'b0;
          in_ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
  assign bus.in_ready = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.Result = res;
  assign bus.Result2 = res2;
  assign bus.Equal = flags.equal;
  assign bus.Overflow = flags.overflow;
  assign bus.UOF = flags.uof;
  assign bus.DivZero = flags.div_zero;
endmodule

// File: tb/tb_multicycle_alu.sv
// tb_multicycle_alu: randomized scoreboard bench for multicycle_alu against an arithmetic reference model
`timescale 1ns/1ps
module tb_multicycle_alu;
  import multicycle_alu_pkg::*;
  localparam int W = 32;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;
  typedef struct {
    logic [3:0] op;
    logic [31:0] res;
    logic [31:0] res2;
    logic eq;
    logic ovf;
    logic uof;
    logic dz;
    int lat;
    int acc;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int stall = 0;
  bit mon_first = 1'b1;
  exp_t q[$];
  multicycle_alu_if #(.WIDTH(W)) bus ();
  multicycle_alu #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask
  function automatic exp_t model(input logic [3:0] s, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    longint sx, sy, t;
    longint unsigned ux, uy;
    sx = $signed(x);
    sy = $signed(y);
    ux = x;
    uy = y;
    e = '{op: s, res: 0, res2: 0, eq: x == y, ovf: 0, uof: 0, dz: 0, lat: 1, acc: 0};
    case (s)
      OP_SLL: e.res = 32'(ux << y[4:0]);
      OP_SRA: e.res = 32'(sx >>> y[4:0]);
      OP_SRL: e.res = 32'(ux >> y[4:0]);
      OP_MUL: begin
        t = sx * sy;
        e.res = t[31:0];
        e.res2 = t[63:32];
        e.lat = W + 1;
      end
`ifdef MULTICYCLE_ALU_DIV_EN
      OP_DIV:
        if (y == 0) begin
          e.res = 32'hFFFFFFFF;
          e.res2 = x;
          e.dz = 1'b1;
        end else begin
          e.lat = W + 1;
          if (sx == SMIN && sy == -1) begin
            e.res = x;
            e.ovf = 1'b1;
          end else begin
            e.res = 32'(sx / sy);
            e.res2 = 32'(sx % sy);
          end
        end
`endif
      OP_ADD: begin
        t = sx + sy;
        e.res = 32'(ux + uy);
        e.ovf = t > SMAX || t < SMIN;
        e.uof = (ux + uy) > 64'hFFFFFFFF;
      end
      OP_SUB: begin
        t = sx - sy;
        e.res = 32'(ux - uy);
        e.ovf = t > SMAX || t < SMIN;
        e.uof = ux < uy;
      end
      OP_AND: e.res = x & y;
      OP_OR: e.res = x | y;
      OP_XOR: e.res = x ^ y;
      OP_NOR: e.res = ~(x | y);
      OP_SLT: e.res = {31'b0, sx < sy};
      OP_SLTU: e.res = {31'b0, ux < uy};
      default: e.eq = 1'b0;
    endcase
    return e;
  endfunction
  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'h7FFFFFFF;
      4: return 32'($urandom_range(0, 40));
      5: return -32'($urandom_range(1, 40));
      default: return $urandom;
    endcase
  endfunction
  task automatic issue(input logic [3:0] s, input logic [31:0] x, input logic [31:0] y);
    int n;
    exp_t e;
    n = 0;
    bus.S = s;
    bus.X = x;
    bus.Y = y;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout op=%0d in_ready=%0b required=1", s, bus.in_ready);
    end else begin
      e = model(s, x, y);
      e.acc = cyc + 1;
      q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.S = 4'($urandom);
    bus.X = $urandom;
    bus.Y = $urandom;
  endtask
  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout pending=%0d required=0", q.size());
      q.delete();
    end
  endtask
  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_result"}, bus.Result, 0);
    chk({tag, "_result2"}, bus.Result2, 0);
    chk({tag, "_flags"}, {bus.Equal, bus.Overflow, bus.UOF, bus.DivZero}, 0);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_first = 1'b1;
        bus.out_ready = 1'b0;
        continue;
      end
      if (!bus.out_valid) begin
        bus.out_ready = 1'b0;
        continue;
      end
      chk("in_ready_low_in_done", bus.in_ready, 0);
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out_valid result=0x%0h required=no_response", bus.Result);
        bus.out_ready = 1'b1;
        continue;
      end
      e = q[0];
      if (mon_first) chk($sformatf("latency_op%0d", e.op), 64'(cyc - e.acc + 1), 64'(e.lat));
      mon_first = 1'b0;
      chk($sformatf("result_op%0d", e.op), bus.Result, e.res);
      chk($sformatf("result2_op%0d", e.op), bus.Result2, e.res2);
      chk($sformatf("equal_op%0d", e.op), bus.Equal, e.eq);
      chk($sformatf("overflow_op%0d", e.op), bus.Overflow, e.ovf);
      chk($sformatf("uof_op%0d", e.op), bus.UOF, e.uof);
      chk($sformatf("divzero_op%0d", e.op), bus.DivZero, e.dz);
      if (stall > 0) begin
        stall--;
        bus.out_ready = 1'b0;
      end else
        bus.out_ready = $urandom_range(0, 2) != 0;
      if (bus.out_ready) begin
        void'(q.pop_front());
        mon_first = 1'b1;
      end
    end
  end
  initial begin
    bus.S = '0;
    bus.X = '0;
    bus.Y = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    #12;
    chk_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_reset", bus.in_ready, 1);
    issue(OP_ADD, 32'h7FFFFFFF, 32'h1);
    issue(OP_MUL, -32'sd3, 32'd7);
    issue(OP_DIV, -32'sd7, 32'd2);
    issue(OP_DIV, 32'd5, 32'd0);
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    issue(OP_SUB, 32'h80000000, 32'h1);
    issue(OP_SUB, 32'd3, 32'd5);
    issue(OP_SRA, 32'h80000000, 32'd31);
    issue(OP_MUL, 32'h80000000, 32'h80000000);
    issue(4'd13, 32'd9, 32'd9);
    wait_drain();
    stall = 5;
    issue(OP_ADD, 32'hFFFFFFFF, 32'hFFFFFFFF);
    issue(OP_XOR, 32'h1234, 32'h1234);
    wait_drain();
    issue(OP_MUL, rnd_opnd(), rnd_opnd());
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    q.delete();
    #1;
    chk_zero_outputs("mid_mul_reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_mid_reset", bus.in_ready, 1);
    chk("out_valid_after_mid_reset", bus.out_valid, 0);
    issue(OP_SLTU, 32'd1, 32'hFFFFFFFF);
    for (int i = 0; i < 90; i++) begin
      if ($urandom_range(0, 9) == 0) stall = $urandom_range(1, 6);
      issue(4'($urandom_range(0, 15)), rnd_opnd(), rnd_opnd());
    end
    wait_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
